pipe_elastic_chain: RTL and testbench

- Parametrised, elastic successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- A chain of DEPTH valid/ready register stages, each DATA_W wide, with:
  - per-stage flush (squash),
  - global stall,
  - live occupancy count,
  - saturating counter of squashed entries.
- Sits between pipeline stages so that hazard and branch logic can freeze or kill in-flight instructions without custom register modules.

---
 rtl/pipe_elastic_chain.sv | 110 +++++++++++
 tb/tb_pipe_elastic_chain.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_chain.sv
// rtl/pipe_elastic_chain.sv - elastic valid/ready register chain with per-stage flush, global stall and drop counter
// Replaces fixed inter-stage pipeline registers so hazard/branch logic can freeze or kill in-flight beats.
module pipe_elastic_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic [DEPTH-1:0]  flush_mask,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Five bits hold the kill popcount for the largest legal DEPTH of 16.
  localparam int KILL_W = 5;
  localparam int SUM_W  = CNT_W + KILL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0]  valid;
  logic [DATA_W-1:0] data [DEPTH];
  logic [DEPTH:0]    rdy;
  logic [DEPTH-1:0]  load;
  logic [DEPTH-1:0]  drain;
  logic [KILL_W-1:0] kills;
  logic [SUM_W-1:0]  drop_sum;
  logic [CNT_W-1:0]  drop_next;

  // Ready ripples from the output back to the entry; a flushed stage counts as free.
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    rdy = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = !stall && (!valid[i] || flush_mask[i] || r);
      rdy[i] = r;
    end
  end

  assign in_ready = rst && rdy[0];

  always_comb begin
    load    = '0;
    drain   = '0;
    load[0] = in_valid && in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = valid[i-1] && !flush_mask[i-1] && rdy[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      drain[i] = rdy[i+1] && !stall;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        data[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          data[i] <= data[i-1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          valid[i] <= 1'b1;
        end else if (flush_mask[i] || drain[i]) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    kills     = '0;
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kills     = kills + KILL_W'(valid[i] & flush_mask[i]);
      occupancy = occupancy + OCC_W'(valid[i]);
    end
    drop_sum  = SUM_W'(drop_cnt) + SUM_W'(kills);
    drop_next = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_next;
    end
  end

  assign out_valid = valid[DEPTH-1] && !stall;
  assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// tb/tb_pipe_elastic_chain.sv - directed self-checking bench for pipe_elastic_chain
module tb_pipe_elastic_chain;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        stall;
  logic [3:0]  flush_mask;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  occupancy;
  logic [15:0] drop_cnt;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_out_data;
  logic [2:0]  sat_occupancy;
  logic [1:0]  sat_drop_cnt;

  int checks;
  int failures;

  pipe_elastic_chain #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .stall(stall),
    .flush_mask(flush_mask), .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  // Same stimulus, narrow counter: only drop_cnt saturation differs.
  pipe_elastic_chain #(.DATA_W(32), .DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .stall(stall),
    .flush_mask(flush_mask), .occupancy(sat_occupancy), .drop_cnt(sat_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush_mask = '0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready got=%0b exp=1", in_ready); end
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c < 8) in_data = 32'h11 + c;
      else in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== (c >= 4 && c <= 11)) begin failures++; $display("FAIL stream_out_valid c=%0d got=%0b exp=%0b", c, out_valid, (c >= 4 && c <= 11)); end
      if (c >= 4 && c <= 11) begin
        checks++; if (out_data !== 32'h11 + c - 4) begin failures++; $display("FAIL stream_out_data c=%0d got=%0h exp=%0h", c, out_data, 32'h11 + c - 4); end
      end
      if (c >= 4 && c <= 8) begin
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL stream_occupancy c=%0d got=%0d exp=4", c, occupancy); end
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'hA0 + k;
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL bp_occupancy got=%0d exp=4", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_data !== 32'hA0) begin failures++; $display("FAIL bp_head got=%0h exp=a0", out_data); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%0b exp=1", in_ready); end
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL bp_after_release_occ got=%0d exp=3", occupancy); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_data !== 32'hA1 + k) begin failures++; $display("FAIL bp_drain k=%0d got=%0h exp=%0h", k, out_data, 32'hA1 + k); end
      tick();
    end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL bp_empty got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'hB0 + k;
      tick();
    end
    in_data = 32'hBF; stall = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0b exp=0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (occupancy !== 3'd4 || out_data !== 32'hB0) begin failures++; $display("FAIL stall_hold k=%0d occ=%0d data=%0h exp occ=4 data=b0", k, occupancy, out_data); end
    end
    stall = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_release_valid got=%0b exp=1", out_valid); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_data !== 32'hB0 + k) begin failures++; $display("FAIL stall_drain k=%0d got=%0h exp=%0h", k, out_data, 32'hB0 + k); end
      tick();
    end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL stall_empty got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hC1;
    tick();
    in_data = 32'hC2;
    tick();
    flush_mask = 4'b0011; in_data = 32'hC9;
    #1;
    checks++; if (in_ready !== 1'b1 || occupancy !== 3'd2) begin failures++; $display("FAIL flush_pre in_ready=%0b occ=%0d exp 1/2", in_ready, occupancy); end
    tick();
    flush_mask = '0; in_valid = 1'b0;
    #1;
    checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL flush_drop_cnt got=%0d exp=2", drop_cnt); end
    checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL flush_occ got=%0d exp=1", occupancy); end
    checks++; if (sat_drop_cnt !== 2'd2) begin failures++; $display("FAIL flush_sat_drop got=%0d exp=2", sat_drop_cnt); end
    seen = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (out_valid) begin
        seen++;
        checks++; if (out_data !== 32'hC9) begin failures++; $display("FAIL flush_survivor got=%0h exp=c9", out_data); end
      end
    end
    checks++; if (seen !== 1) begin failures++; $display("FAIL flush_beats got=%0d exp=1", seen); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      in_valid = 1'b1; in_data = 32'hE0 + n;
      tick();
      in_valid = 1'b0; flush_mask = 4'b0001;
      tick();
      flush_mask = '0;
      #1;
      checks++; if (sat_drop_cnt !== 2'd3) begin failures++; $display("FAIL sat_single n=%0d got=%0d exp=3", n, sat_drop_cnt); end
      checks++; if (drop_cnt !== 16'd3 + n) begin failures++; $display("FAIL sat_wide n=%0d got=%0d exp=%0d", n, drop_cnt, 3 + n); end
    end
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'hE4 + k;
      tick();
    end
    in_valid = 1'b0; stall = 1'b1; flush_mask = 4'b0111;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sat_stall_in_ready got=%0b exp=0", in_ready); end
    tick();
    stall = 1'b0; flush_mask = '0;
    #1;
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL sat_stall_flush_occ got=%0d exp=0", occupancy); end
    checks++; if (drop_cnt !== 16'd7) begin failures++; $display("FAIL sat_wide_final got=%0d exp=7", drop_cnt); end
    checks++; if (sat_drop_cnt !== 2'd3) begin failures++; $display("FAIL sat_final got=%0d exp=3", sat_drop_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'hF0 + k;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++; if (occupancy !== 3'd3 || out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre occ=%0d valid=%0b exp 3/1", occupancy, out_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL arst_occupancy got=%0d exp=0", occupancy); end
    checks++; if (drop_cnt !== 16'd0 || sat_drop_cnt !== 2'd0) begin failures++; $display("FAIL arst_drop got=%0d/%0d exp=0/0", drop_cnt, sat_drop_cnt); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_in_ready got=%0b exp=0", in_ready); end
    #1 rst = 1'b1;
    in_valid = 1'b1; in_data = 32'hD0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_lat c=1 got=%0b exp=0", out_valid); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++; if (out_valid !== (c == 4)) begin failures++; $display("FAIL arst_lat c=%0d got=%0b exp=%0b", c, out_valid, (c == 4)); end
    end
    checks++; if (out_data !== 32'hD0) begin failures++; $display("FAIL arst_data got=%0h exp=d0", out_data); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
